seg7_pair_monitor: RTL

Inverse of the team's two-digit hex display driver. The block samples the pair of active-low 7-segment buses driven to HEX1/HEX0 and decodes them back into the 5-bit value {carry, nibble} they represent. A value is accepted only after it has been stable for a programmable number of clocks. Illegal patterns are flagged and counted. It sits beside the display driver as an in-system checker and as the bench's scoreboard front end.

---
 rtl/seg7_pair_monitor.sv | 112 +++++++++++
 1 files changed

// File: rtl/seg7_pair_monitor.sv
// Decodes a two-digit active-low 7-segment pair back into {carry, nibble},
// accepting a pattern only after it has been stable for STABLE_CYCLES clocks.
module seg7_pair_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [0:6]       HEX1,
    input  logic [0:6]       HEX0,
    output logic [4:0]       value,
    output logic             valid,
    output logic             invalid,
    output logic             update,
    output logic [ERR_W-1:0] err_count
);

    // state  | meaning
    // IDLE   | post-reset, blank pair assumed captured, counting
    // SETTLE | new pattern captured, counting stable samples
    // LOCKED | legal pattern accepted, value holds its decode
    // FAULT  | illegal pattern persisted long enough, counted once

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, FAULT} state_t;

    state_t           state, state_n;
    logic [13:0]      samp, samp_n, pair_in;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       nib;
    logic             carry, hex0_ok, hex1_ok, legal;
    logic             decide, lock_n, fault_n;

    assign pair_in = {HEX1, HEX0};

    // The input pair is decoded directly so a lock on the capturing edge sees the new pattern.
    always_comb begin
        nib     = 4'h0;
        hex0_ok = 1'b1;
        case (HEX0)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
            default:    hex0_ok = 1'b0;
        endcase
        carry   = (HEX1 == 7'b1001111);
        hex1_ok = carry || (HEX1 == 7'b1111111);
        legal   = hex0_ok && hex1_ok;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            samp      <= '1;
            cnt       <= '0;
            value     <= '0;
            update    <= 1'b0;
            err_count <= '0;
        end else begin
            state  <= state_n;
            samp   <= samp_n;
            cnt    <= cnt_n;
            update <= lock_n;
            if (lock_n)
                value <= {carry, nib};
            if (fault_n && (err_count != {ERR_W{1'b1}}))
                err_count <= err_count + ERR_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        samp_n  = samp;
        cnt_n   = cnt;
        decide  = 1'b0;
        if (pair_in != samp) begin
            samp_n  = pair_in;
            cnt_n   = CNT_ONE;
            state_n = SETTLE;
            decide  = (CNT_ONE == CNT_TGT);
        end else if ((state == IDLE) || (state == SETTLE)) begin
            cnt_n  = cnt + CNT_ONE;
            decide = (cnt_n == CNT_TGT);
        end
        if (decide)
            state_n = legal ? LOCKED : FAULT;
        lock_n  = decide && legal;
        fault_n = decide && !legal;
    end

    always_comb begin
        valid   = (state == LOCKED);
        invalid = (state == FAULT);
    end

endmodule
